// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starvation_counter.sv
// Counts consecutive data grants taken while a fetch waits; saturates at STARVE_LIMIT.
module starvation_counter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit_hit
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count < CNT_W'(STARVE_LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_limit_hit = (r_count >= CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instruction_valid,
    input  logic [ADDR_W-1:0]     instruction_addr,
    output logic                  instruction_ready,
    input  logic                  instruction_ack,
    output logic [DATA_W-1:0]     instruction_read,
    input  logic                  data_read_valid,
    input  logic                  data_write_valid,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_write,
    input  logic [DATA_W/8-1:0]   data_write_byte,
    output logic                  data_ready,
    input  logic                  data_ack,
    output logic [DATA_W-1:0]     data_read,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_done,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  proto_err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    owner_t            r_owner;
    logic              r_instrReady;
    logic              r_dataReady;
    logic [DATA_W-1:0] r_instrRead;
    logic [DATA_W-1:0] r_dataRead;
    logic              r_memReq;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [BE_W-1:0]   r_memBe;
    logic              r_protoErr;

    logic              w_dataReq;
    logic              w_limitHit;
    logic              w_grantData;
    logic              w_grantInstr;
    logic              w_cntInc;
    logic              w_cntClr;
    logic              w_ownerAck;
    logic [ADDR_W-1:0] w_fetchAddr;

    // Data wins unless a fetch has already been passed over STARVE_LIMIT times.
    assign w_dataReq    = data_read_valid | data_write_valid;
    assign w_grantData  = w_dataReq && (!instruction_valid || !w_limitHit);
    assign w_grantInstr = !w_grantData && instruction_valid;
    assign w_cntInc     = (r_state == IDLE) && w_grantData && instruction_valid;
    assign w_cntClr     = (r_state == IDLE) &&
                          (w_grantInstr || (w_grantData && !instruction_valid));
    assign w_fetchAddr  = instruction_addr & ~ADDR_W'(3);
    assign w_ownerAck   = (r_owner == OWN_INSTR) ? (instruction_ack && r_instrReady)
                                                 : (data_ack && r_dataReady);

    starvation_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_cntInc),
        .i_clr       (w_cntClr),
        .o_limit_hit (w_limitHit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_INSTR;
            r_instrReady <= 1'b0;
            r_dataReady  <= 1'b0;
            r_instrRead  <= '0;
            r_dataRead   <= '0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_memBe      <= '0;
            r_protoErr   <= 1'b0;
        end else begin
            if (data_read_valid && data_write_valid) begin
                r_protoErr <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_grantData) begin
                        r_owner    <= OWN_DATA;
                        r_memReq   <= 1'b1;
                        r_memWe    <= data_write_valid;
                        r_memAddr  <= data_addr;
                        r_memWdata <= data_write_valid ? data_write : '0;
                        r_memBe    <= data_write_valid ? data_write_byte : '1;
                        r_state    <= ACCESS;
                    end else if (w_grantInstr) begin
                        r_owner    <= OWN_INSTR;
                        r_memReq   <= 1'b1;
                        r_memWe    <= 1'b0;
                        r_memAddr  <= w_fetchAddr;
                        r_memWdata <= '0;
                        r_memBe    <= '1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_done) begin
                        r_memReq <= 1'b0;
                        if (r_owner == OWN_INSTR) begin
                            r_instrRead  <= mem_rdata;
                            r_instrReady <= 1'b1;
                        end else begin
                            r_dataRead  <= r_memWe ? '0 : mem_rdata;
                            r_dataReady <= 1'b1;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_ownerAck) begin
                        r_instrReady <= 1'b0;
                        r_dataReady  <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instruction_ready = r_instrReady;
    assign instruction_read  = r_instrRead;
    assign data_ready        = r_dataReady;
    assign data_read         = r_dataRead;
    assign mem_req           = r_memReq;
    assign mem_we            = r_memWe;
    assign mem_addr          = r_memAddr;
    assign mem_wdata         = r_memWdata;
    assign mem_be            = r_memBe;
    assign proto_err         = r_protoErr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-edge vector table for fetch/store/load, plus starvation, ack and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instruction_valid;
    logic [31:0] instruction_addr;
    logic        instruction_ready;
    logic        instruction_ack;
    logic [31:0] instruction_read;
    logic        data_read_valid;
    logic        data_write_valid;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [3:0]  data_write_byte;
    logic        data_ready;
    logic        data_ack;
    logic [31:0] data_read;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        proto_err;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        string       name;
        logic        iv;
        logic [31:0] iaddr;
        logic        iack;
        logic        drv;
        logic        dwv;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dbe;
        logic        dack;
        logic        mdone;
        logic [31:0] mrdata;
        logic        eIr;
        logic        eDr;
        logic        eReq;
        logic        eWe;
        logic [31:0] eAddr;
        logic [3:0]  eBe;
        logic [31:0] eWdata;
        logic [31:0] eIread;
        logic [31:0] eDread;
        logic        ePerr;
    } vec_t;

    vec_t vecs[$];

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_W       (32),
        .DATA_W       (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instruction_valid (instruction_valid),
        .instruction_addr  (instruction_addr),
        .instruction_ready (instruction_ready),
        .instruction_ack   (instruction_ack),
        .instruction_read  (instruction_read),
        .data_read_valid   (data_read_valid),
        .data_write_valid  (data_write_valid),
        .data_addr         (data_addr),
        .data_write        (data_write),
        .data_write_byte   (data_write_byte),
        .data_ready        (data_ready),
        .data_ack          (data_ack),
        .data_read         (data_read),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_done          (mem_done),
        .mem_rdata         (mem_rdata),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic clearInputs();
        instruction_valid = 1'b0;
        instruction_addr  = '0;
        instruction_ack   = 1'b0;
        data_read_valid   = 1'b0;
        data_write_valid  = 1'b0;
        data_addr         = '0;
        data_write        = '0;
        data_write_byte   = '0;
        data_ack          = 1'b0;
        mem_done          = 1'b0;
        mem_rdata         = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearInputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Drives one vector's inputs across a single rising edge.
    task automatic applyStimulus(input vec_t v);
        instruction_valid = v.iv;
        instruction_addr  = v.iaddr;
        instruction_ack   = v.iack;
        data_read_valid   = v.drv;
        data_write_valid  = v.dwv;
        data_addr         = v.daddr;
        data_write        = v.dwdata;
        data_write_byte   = v.dbe;
        data_ack          = v.dack;
        mem_done          = v.mdone;
        mem_rdata         = v.mrdata;
        tick();
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".ir"},    32'(instruction_ready), 32'(v.eIr));
        checkOutput({v.name, ".dr"},    32'(data_ready),        32'(v.eDr));
        checkOutput({v.name, ".req"},   32'(mem_req),           32'(v.eReq));
        checkOutput({v.name, ".we"},    32'(mem_we),            32'(v.eWe));
        checkOutput({v.name, ".addr"},  mem_addr,               v.eAddr);
        checkOutput({v.name, ".be"},    32'(mem_be),            32'(v.eBe));
        checkOutput({v.name, ".wdata"}, mem_wdata,              v.eWdata);
        checkOutput({v.name, ".iread"}, instruction_read,       v.eIread);
        checkOutput({v.name, ".dread"}, data_read,              v.eDread);
        checkOutput({v.name, ".perr"},  32'(proto_err),         32'(v.ePerr));
    endtask

    // One access in the starvation run: wait for grant, answer it, ack the owner.
    task automatic serveGrant(input int k, input byte expOwner);
        int  n;
        logic isData;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req && n < 8);
        if (!mem_req) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL starve.grant%0d: got no mem_req, expected a grant", k);
            return;
        end
        checkOutput($sformatf("starve.owner%0d", k), mem_addr,
                    (expOwner == "D") ? 32'h0000_0200 : 32'h0000_0100);
        isData = (mem_addr == 32'h0000_0200);
        mem_done  = 1'b1;
        mem_rdata = 32'(k);
        tick();
        mem_done  = 1'b0;
        checkOutput($sformatf("starve.ready%0d", k), {30'b0, instruction_ready, data_ready},
                    (expOwner == "D") ? 32'h1 : 32'h2);
        if (isData) data_ack = 1'b1;
        else        instruction_ack = 1'b1;
        tick();
        data_ack        = 1'b0;
        instruction_ack = 1'b0;
    endtask

    initial begin
        string order;
        order = "DDDDIDDDDI";

        // Fetch, then store, then load, one row per rising edge.
        vecs.push_back('{"f_grant", 1'b1, 32'h0001_0002, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{"f_wait", 1'b1, 32'h0001_0002, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{"f_done", 1'b1, 32'h0001_0002, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0050_0093,
                         1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"f_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"f_ack", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"f_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"s_grant", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 4'h3, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"s_wait", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 4'h3, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"s_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b1, 32'h1234_5678,
                         1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 4'h3, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"s_ack", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 4'h3, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"l_grant", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0050_0093, 32'h0, 1'b0});
        vecs.push_back('{"l_done", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_BEEF,
                         1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0050_0093, 32'h0000_BEEF, 1'b0});
        vecs.push_back('{"l_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0050_0093, 32'h0000_BEEF, 1'b0});
        vecs.push_back('{"l_ack", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0050_0093, 32'h0000_BEEF, 1'b0});
        vecs.push_back('{"l_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0050_0093, 32'h0000_BEEF, 1'b0});

        doReset();
        checkOutput("reset.req",   32'(mem_req), 32'h0);
        checkOutput("reset.ready", {30'b0, instruction_ready, data_ready}, 32'h0);
        checkOutput("reset.addr",  mem_addr, 32'h0);
        checkOutput("reset.perr",  32'(proto_err), 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
        end

        // Starvation: both requesters held continuously.
        doReset();
        instruction_valid = 1'b1;
        instruction_addr  = 32'h0000_0100;
        data_read_valid   = 1'b1;
        data_addr         = 32'h0000_0200;
        for (int k = 0; k < 10; k++) begin
            serveGrant(k, order[k]);
        end
        clearInputs();
        tick();

        // Ack already high before data_ready rises.
        doReset();
        data_read_valid = 1'b1;
        data_addr       = 32'h0000_0040;
        data_ack        = 1'b1;
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        mem_done        = 1'b0;
        data_read_valid = 1'b0;
        checkOutput("earlyack.ready_rise", 32'(data_ready), 32'h1);
        tick();
        checkOutput("earlyack.ready_clear", 32'(data_ready), 32'h0);
        checkOutput("earlyack.dread", data_read, 32'h0000_0077);
        data_ack = 1'b0;
        tick();

        // Non-owner ack during a data response is ignored.
        data_read_valid = 1'b1;
        data_addr       = 32'h0000_0044;
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'h0000_0088;
        tick();
        mem_done        = 1'b0;
        data_read_valid = 1'b0;
        instruction_ack = 1'b1;
        tick();
        checkOutput("wrongack.dr", 32'(data_ready), 32'h1);
        checkOutput("wrongack.ir", 32'(instruction_ready), 32'h0);
        tick();
        checkOutput("wrongack.dr_held", 32'(data_ready), 32'h1);
        instruction_ack = 1'b0;
        data_ack        = 1'b1;
        tick();
        checkOutput("wrongack.dr_clear", 32'(data_ready), 32'h0);
        checkOutput("wrongack.dread", data_read, 32'h0000_0088);
        data_ack = 1'b0;

        // Simultaneous load and store: store wins, proto_err sticks until reset.
        doReset();
        data_read_valid  = 1'b1;
        data_write_valid = 1'b1;
        data_addr        = 32'h0000_0300;
        data_write       = 32'hA5A5_A5A5;
        data_write_byte  = 4'hC;
        tick();
        checkOutput("proto.we",   32'(mem_we), 32'h1);
        checkOutput("proto.be",   32'(mem_be), 32'hC);
        checkOutput("proto.perr", 32'(proto_err), 32'h1);
        mem_done  = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        clearInputs();
        checkOutput("proto.dread", data_read, 32'h0);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        tick();
        tick();
        checkOutput("proto.sticky", 32'(proto_err), 32'h1);
        doReset();
        checkOutput("proto.cleared", 32'(proto_err), 32'h0);

        // Reset while an access is in flight, then a late mem_done.
        data_read_valid = 1'b1;
        data_addr       = 32'h0000_0100;
        tick();
        checkOutput("midrst.req_before", 32'(mem_req), 32'h1);
        checkOutput("midrst.addr", mem_addr, 32'h0000_0100);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst.req_async", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        data_read_valid = 1'b0;
        mem_done        = 1'b1;
        mem_rdata       = 32'h0000_00FF;
        tick();
        mem_done = 1'b0;
        tick();
        tick();
        checkOutput("midrst.ready", {30'b0, instruction_ready, data_ready}, 32'h0);
        checkOutput("midrst.req_after", 32'(mem_req), 32'h0);
        checkOutput("midrst.dread", data_read, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester and the data (load/store) requester of the riscv32 core.
- Uses a valid/ready/ack handshake on each requester side and a req/done handshake on the memory side.
- Data requests normally win. A starvation counter forces an instruction grant after STARVE_LIMIT consecutive data grants taken while a fetch was waiting.
- Sits between the control module and a single memory instance, replacing the separate instruction_memory/memory paths.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while instruction_valid is pending; range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- instruction_valid  input  1  fetch request; held until instruction_ready is seen.
- instruction_addr  input  ADDR_W  fetch address; bits [1:0] are forced to 0 at the memory.
- instruction_ready  output  1  fetch data valid; held until instruction_ack.
- instruction_ack  input  1  requester has consumed instruction_read.
- instruction_read  output  DATA_W  fetched word.
- data_read_valid  input  1  load request.
- data_write_valid  input  1  store request.
- data_addr  input  ADDR_W  load/store address.
- data_write  input  DATA_W  store data.
- data_write_byte  input  DATA_W/8  store byte enables.
- data_ready  output  1  load/store complete; held until data_ack.
- data_ack  input  1  requester has consumed the response.
- data_read  output  DATA_W  load data; 0 for stores.
- mem_req  output  1  memory access request; held until mem_done.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  write data.
- mem_be  output  DATA_W/8  byte enables; all-ones for reads.
- mem_done  input  1  one-cycle pulse; access complete, mem_rdata valid in the same cycle.
- mem_rdata  input  DATA_W  read data.
- proto_err  output  1  sticky flag; set when data_read_valid and data_write_valid are high together.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset==0):
  - state = IDLE; every output = 0; starvation counter = 0; proto_err = 0.
  - An in-flight memory access is abandoned. mem_req drops immediately and a late mem_done after reset release is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests. If either port is requesting, register the owner and memory fields, set mem_req=1 and go to ACCESS.
  - mem_req is visible the cycle after the request is sampled.
- Arbitration, evaluated in IDLE only:
  - If the data port requests and (instruction_valid==0 or counter<STARVE_LIMIT): grant data. Counter increments when instruction_valid==1, saturating at STARVE_LIMIT.
  - Otherwise, if instruction_valid==1: grant instruction and clear the counter to 0.
  - When a data grant is taken with instruction_valid==0, the counter clears to 0.
- Simultaneous load and store request: treated as a store, and proto_err is set. proto_err stays set until reset.
- ACCESS:
  - mem_addr, mem_we, mem_wdata and mem_be stay stable while mem_req==1.
  - On mem_done: clear mem_req, capture mem_rdata (data_read is 0 for stores), assert the owner's ready next cycle and go to RESP.
  - There is no timeout; ACCESS waits indefinitely.
- RESP:
  - The owner's ready is held until that owner's ack is sampled high.
  - Then ready clears, read data holds its value, and the FSM returns to IDLE.
  - A new grant is possible on the cycle after the ack.
- Ack rules:
  - An ack from the non-owner is ignored.
  - An ack high on the same edge that ready rises is not consumed; only an ack sampled while ready==1 counts.
- Minimum latency (mem_done in the cycle after mem_req):
  - request sampled at edge 0; mem_req at edge 1; mem_done seen at edge 2; ready at edge 3.
  - With ack at edge 4, back-to-back grants are 5 cycles apart.
- Requests arriving during ACCESS/RESP are not sampled until IDLE; requesters must hold valid.
- Only one outstanding access at a time; instruction_ready and data_ready are never high together.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - owner enum (OWN_INSTR, OWN_DATA)
  - width constants
- One sub-module: starvation_counter (saturating up-counter with clear, STARVE_LIMIT parameter, outputs limit_hit).
- FSM and datapath registers live in mem_port_arbiter.

Test Plan:
- Reset mid-access: assert reset while mem_req=1, addr 0x100 → mem_req=0 at once; no ready after release even if mem_done pulses.
- Single fetch: instruction_valid, addr 0x00010002, mem_done one cycle after mem_req with rdata 0x00500093 → mem_addr=0x00010000, mem_be=0xF, instruction_ready at the 3rd edge after the request, instruction_read=0x00500093, held until ack.
- Store then load:
  - store 0xDEADBEEF to 0x2000 with byte enable 0x3 → mem_we=1, mem_be=0x3; data_ready then data_read=0.
  - load from 0x2000 with rdata 0x0000BEEF → data_read=0x0000BEEF.
- Starvation with STARVE_LIMIT=4: fetch valid and data valid held continuously → grant order D,D,D,D,I,D,D,D,D,I; counter clears after each instruction grant.
- Simultaneous load and store on the data port → treated as a store (mem_we=1), proto_err=1 and stays 1 until reset.
- Ack timing:
  - data_ack held high before data_ready rises → ready stays high for at least one full cycle.
  - instruction_ack during a data response → ignored; state remains RESP.
